// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes, FSM
// state encoding and the default data-segment base address.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Size code 3 behaves as a word access, so bit 1 alone identifies a word.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// Big-endian lane steering: load extraction with sign/zero extension, and
// the store merge used by sub-word read-modify-write.
module lane_mux
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = 8'h00;
        half_v    = lane[1] ? word[15:0] : word[31:16];
        load_data = word;
        merged    = word;
        case (lane)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
        if (is_word(size)) begin
            load_data = word;
            merged    = wdata;
        end else if (size == SZ_HALF) begin
            load_data = sgn ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            if (lane[1]) merged[15:0]  = wdata[15:0];
            else         merged[31:16] = wdata[15:0];
        end else begin
            load_data = sgn ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
            case (lane)
                2'd0:    merged[31:24] = wdata[7:0];
                2'd1:    merged[23:16] = wdata[7:0];
                2'd2:    merged[15:8]  = wdata[7:0];
                default: merged[7:0]   = wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between EX/MEM and the word-wide big-endian data memory.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
    parameter int          DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DEPTH_U = DEPTH_BYTES;

    state_t      state_q, state_d;
    logic        accept, trap, err_flag;
    logic [31:0] diff;
    logic [9:0]  off_raw, off_al;

    logic        wr_q, sgn_q;
    logic [1:0]  size_q;
    logic [9:0]  off_q;
    logic [31:0] wdata_q, word_q, rdata_q;
    logic [31:0] mux_word, mux_load, mux_merged;

    assign accept  = req_valid && (state_q == IDLE);
    assign diff    = req_addr - DATA_BASE;
    assign off_raw = 10'(diff % DEPTH_U);

    always_comb begin
        off_al = off_raw;
        if (is_word(req_size))        off_al[1:0] = 2'b00;
        else if (req_size == SZ_HALF) off_al[0]   = 1'b0;
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    always_comb begin
        trap = 1'b0;
        if (is_word(req_size))        trap = |off_raw[1:0];
        else if (req_size == SZ_HALF) trap = off_raw[0];
    end

    always_ff @(posedge clk) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= trap;
    end

    assign err_flag = err_q;
`else
    assign trap     = 1'b0;
    assign err_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (trap)                                state_d = DONE;
                    else if (req_wr && is_word(req_size))    state_d = WR;
                    else                                     state_d = RD;
                end
            end
            RD:      if (mem_ack) state_d = wr_q ? MERGE : DONE;
            MERGE:   state_d = WR;
            WR:      if (mem_ack) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Request and data capture; qualified by the FSM, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_wr;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            off_q   <= off_al;
            wdata_q <= req_wdata;
            word_q  <= req_wdata;
        end else if (state_q == RD && mem_ack) begin
            rdata_q <= mux_load;
            word_q  <= mem_rdata;
        end else if (state_q == MERGE) begin
            word_q  <= mux_merged;
        end
    end

    assign mux_word = (state_q == MERGE) ? word_q : mem_rdata;

    lane_mux u_lane_mux (
        .size      (size_q),
        .sgn       (sgn_q),
        .lane      (off_q[1:0]),
        .word      (mux_word),
        .wdata     (wdata_q),
        .load_data (mux_load),
        .merged    (mux_merged)
    );

    assign req_ready  = (state_q == IDLE);
    assign busy       = !req_ready;
    assign resp_valid = (state_q == DONE);
    assign resp_err   = resp_valid && err_flag;
    assign resp_rdata = (resp_valid && !wr_q && !err_flag) ? rdata_q : 32'h0;
    assign mem_req    = (state_q == RD) || (state_q == WR);
    assign mem_wr     = (state_q == WR);
    assign mem_addr   = mem_req ? {off_q[9:2], 2'b00} : 10'h000;
    assign mem_wdata  = mem_wr ? word_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory and
// adjustable ack delay; honours MISALIGN_TRAP_EN when set.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_wr, mem_ack;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    int          wcnt = 0;
    int          mreq_cycles = 0;
    logic [9:0]  last_waddr = '0, last_raddr = '0;
    logic [31:0] last_wdata = '0;

    assign mem_ack   = mem_req && (wcnt >= ack_delay);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req) mreq_cycles <= mreq_cycles + 1;
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
        if (mem_req && mem_ack) begin
            if (mem_wr) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end else begin
                last_raddr <= mem_addr;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int nreq, output logic rdy);
        int start;
        start      = mreq_cycles;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) chk("resp_timeout", {31'b0, resp_valid}, 32'h1);
        rd  = resp_rdata;
        err = resp_err;
        rdy = req_ready;
        @(posedge clk); #1;
        nreq = mreq_cycles - start;
    endtask

    logic [31:0] rd;
    logic        err, rdy;
    int          lat, nreq;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store then load
        txn(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, rd, err, lat, nreq, rdy);
        chk("sw_lat", lat, 2);
        chk("sw_addr", {22'b0, last_waddr}, 32'h4);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_rdata_zero", rd, 32'h0);
        chk("done_not_ready", {31'b0, rdy}, 32'h0);
        txn(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, rd, err, lat, nreq, rdy);
        chk("lw_data", rd, 32'hDEAD_BEEF);
        chk("lw_lat", lat, 2);
        chk("lw_err", {31'b0, err}, 32'h0);

        // Byte read-modify-write
        txn(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'h1122_3344, rd, err, lat, nreq, rdy);
        txn(1'b1, 2'd0, 1'b0, 32'h1001_000A, 32'h0000_00AA, rd, err, lat, nreq, rdy);
        chk("sb_lat", lat, 4);
        chk("sb_wdata", last_wdata, 32'h1122_AA44);
        chk("sb_addr", {22'b0, last_waddr}, 32'h8);
        chk("sb_nreq", nreq, 2);
        txn(1'b0, 2'd0, 1'b1, 32'h1001_000A, 32'h0, rd, err, lat, nreq, rdy);
        chk("lb_neg", rd, 32'hFFFF_FFAA);
        txn(1'b0, 2'd0, 1'b0, 32'h1001_000A, 32'h0, rd, err, lat, nreq, rdy);
        chk("lbu", rd, 32'h0000_00AA);

        // Halfword loads and store
        txn(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'h8001_1234, rd, err, lat, nreq, rdy);
        txn(1'b0, 2'd1, 1'b1, 32'h1001_0008, 32'h0, rd, err, lat, nreq, rdy);
        chk("lh_neg", rd, 32'hFFFF_8001);
        txn(1'b0, 2'd1, 1'b0, 32'h1001_000A, 32'h0, rd, err, lat, nreq, rdy);
        chk("lhu", rd, 32'h0000_1234);
        txn(1'b0, 2'd0, 1'b1, 32'h1001_000B, 32'h0, rd, err, lat, nreq, rdy);
        chk("lb_pos", rd, 32'h0000_0034);
        txn(1'b1, 2'd1, 1'b0, 32'h1001_000A, 32'h1234_BEEF, rd, err, lat, nreq, rdy);
        chk("sh_wdata", last_wdata, 32'h8001_BEEF);
        txn(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, rd, err, lat, nreq, rdy);
        chk("lw_after_sh", rd, 32'h8001_BEEF);

        // Address wrap at both ends of the window
        txn(1'b1, 2'd2, 1'b0, 32'h1001_03FC, 32'h1234_56C5, rd, err, lat, nreq, rdy);
        txn(1'b0, 2'd0, 1'b0, 32'h1001_03FF, 32'h0, rd, err, lat, nreq, rdy);
        chk("wrap_lbu", rd, 32'h0000_00C5);
        chk("wrap_raddr", {22'b0, last_raddr}, 32'h3FC);
        txn(1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'h0, rd, err, lat, nreq, rdy);
        chk("below_base_lw", rd, 32'h1234_56C5);

        // Misaligned accesses
        txn(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'hCAFE_F00D, rd, err, lat, nreq, rdy);
        txn(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0, rd, err, lat, nreq, rdy);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lw_err", {31'b0, err}, 32'h1);
        chk("mis_lw_rdata", rd, 32'h0);
        chk("mis_lw_nreq", nreq, 0);
        chk("mis_lw_lat", lat, 1);
`else
        chk("mis_lw_err", {31'b0, err}, 32'h0);
        chk("mis_lw_rdata", rd, 32'hCAFE_F00D);
        chk("mis_lw_raddr", {22'b0, last_raddr}, 32'h0);
        chk("mis_lw_lat", lat, 2);
`endif
        txn(1'b0, 2'd1, 1'b1, 32'h1001_0001, 32'h0, rd, err, lat, nreq, rdy);
`ifdef MISALIGN_TRAP_EN
        chk("mis_lh_err", {31'b0, err}, 32'h1);
        chk("mis_lh_nreq", nreq, 0);
`else
        chk("mis_lh_rdata", rd, 32'hFFFF_CAFE);
        chk("mis_lh_err", {31'b0, err}, 32'h0);
`endif

        // Delayed ack: outputs hold steady while the write waits
        ack_delay  = 1000;
        req_valid  = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr   = 32'h1001_0010; req_wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_mem_req", {31'b0, mem_req}, 32'h1);
            chk("hold_mem_wr", {31'b0, mem_wr}, 32'h1);
            chk("hold_mem_addr", {22'b0, mem_addr}, 32'h10);
            chk("hold_mem_wdata", mem_wdata, 32'h55AA_55AA);
            chk("hold_busy", {31'b0, busy}, 32'h1);
            @(posedge clk); #1;
        end
        ack_delay = 0;
        @(posedge clk); #1;
        chk("hold_done", {31'b0, resp_valid}, 32'h1);
        @(posedge clk); #1;
        txn(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, rd, err, lat, nreq, rdy);
        chk("hold_lw", rd, 32'h55AA_55AA);

        // Reset during a stalled write abandons it
        ack_delay  = 1000;
        req_valid  = 1'b1; req_wr = 1'b1; req_size = 2'd2;
        req_addr   = 32'h1001_0010; req_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_req", {31'b0, mem_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
        chk("abort_ready", {31'b0, req_ready}, 32'h1);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        rst = 1'b1;
        ack_delay = 0;
        @(posedge clk); #1;
        txn(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, rd, err, lat, nreq, rdy);
        chk("abort_mem_intact", rd, 32'h55AA_55AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
